// File: rtl/cursor_overlay.sv
// cursor_overlay: mixes a 16x16 hardware cursor into a pixel stream.
// Three-stage pipeline: window test and ROM address, wait for the registered
// ROM read, then colour mix. The cursor position is double-buffered so it
// only moves on frame_start.
module cursor_overlay #(
    parameter int                 H_BITS        = 11,
    parameter int                 V_BITS        = 10,
    parameter int                 COLOR_W       = 12,
    parameter logic [COLOR_W-1:0] CONTOUR_COLOR = 12'h000,
    parameter logic [COLOR_W-1:0] FILL_COLOR    = 12'hFFF,
    parameter logic               SYNC_IDLE     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cursor_en,
    input  logic               fill_solid,
    input  logic [H_BITS-1:0]  mouse_x,
    input  logic [V_BITS-1:0]  mouse_y,
    input  logic               mouse_vld,
    input  logic               frame_start,
    input  logic [H_BITS-1:0]  hcnt,
    input  logic [V_BITS-1:0]  vcnt,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [COLOR_W-1:0] rgb_in,
    output logic [3:0]         rom_x,
    output logic [3:0]         rom_y,
    input  logic [1:0]         rom_data,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [COLOR_W-1:0] rgb_out
);

    // Per-pixel state carried alongside the pixel through stages 1 and 2.
    typedef struct packed {
        logic               win;
        logic               en;
        logic               fill;
        logic               de;
        logic               hs;
        logic               vs;
        logic [COLOR_W-1:0] rgb;
    } stage_t;

    localparam stage_t STAGE_RST = '{
        win: 1'b0, en: 1'b0, fill: 1'b0, de: 1'b0,
        hs: SYNC_IDLE, vs: SYNC_IDLE, rgb: '0
    };

    localparam logic [1:0] CODE_CONTOUR = 2'b01;
    localparam logic [1:0] CODE_FILL    = 2'b10;

    logic [H_BITS-1:0]  pend_x, act_x;
    logic [V_BITS-1:0]  pend_y, act_y;
    logic [H_BITS:0]    x_end;
    logic [V_BITS:0]    y_end;
    logic               win_c;
    stage_t             s1, s2;
    logic [COLOR_W-1:0] mix_rgb;

    // Double-buffered cursor position: pending on mouse_vld, active on frame_start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_x <= '0;
            pend_y <= '0;
            act_x  <= '0;
            act_y  <= '0;
        end else begin
            if (mouse_vld) begin
                pend_x <= mouse_x;
                pend_y <= mouse_y;
            end
            // NOTE: non-blocking assignment makes act take the old pend when both strobes coincide.
            if (frame_start) begin
                act_x <= pend_x;
                act_y <= pend_y;
            end
        end
    end

    // Window end computed one bit wider so the cursor clips at the screen edge.
    assign x_end = {1'b0, act_x} + (H_BITS + 1)'(16);
    assign y_end = {1'b0, act_y} + (V_BITS + 1)'(16);
    assign win_c = (hcnt >= act_x) && ({1'b0, hcnt} < x_end) &&
                   (vcnt >= act_y) && ({1'b0, vcnt} < y_end);

    // Stage 1: ROM address (driven regardless of window) and captured pixel context.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_x <= '0;
            rom_y <= '0;
            s1    <= STAGE_RST;
        end else begin
            rom_x <= hcnt[3:0] - act_x[3:0];
            rom_y <= vcnt[3:0] - act_y[3:0];
            s1    <= '{win: win_c, en: cursor_en, fill: fill_solid, de: de_in,
                       hs: hsync_in, vs: vsync_in, rgb: rgb_in};
        end
    end

    // Stage 2: hold the pixel context while the ROM registers its read.
    always_ff @(posedge clk) begin
        if (!rst_n) s2 <= STAGE_RST;
        else        s2 <= s1;
    end

    // Colour mix of the returned cursor code over the background pixel.
    always_comb begin
        // NOTE: default assigned first so no path leaves mix_rgb unassigned (no latch).
        mix_rgb = s2.rgb;
        if (!s2.de) begin
            mix_rgb = '0;
        end else if (s2.win && s2.en) begin
            case (rom_data)
                CODE_CONTOUR: mix_rgb = CONTOUR_COLOR;
                CODE_FILL:    if (s2.fill) mix_rgb = FILL_COLOR;
                default:      mix_rgb = s2.rgb;
            endcase
        end
    end

    // Stage 3: registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_out    <= 1'b0;
            hsync_out <= SYNC_IDLE;
            vsync_out <= SYNC_IDLE;
            rgb_out   <= '0;
        end else begin
            de_out    <= s2.de;
            hsync_out <= s2.hs;
            vsync_out <= s2.vs;
            rgb_out   <= mix_rgb;
        end
    end

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed testbench for cursor_overlay. A small behavioural cursor ROM
// answers rom_x/rom_y one cycle later; every pixel driven is queued with its
// hand-computed expected output and compared three cycles later.
module tb_cursor_overlay;

    localparam int H_BITS  = 11;
    localparam int V_BITS  = 10;
    localparam int COLOR_W = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cursor_en, fill_solid, mouse_vld, frame_start;
    logic [H_BITS-1:0]  mouse_x, hcnt;
    logic [V_BITS-1:0]  mouse_y, vcnt;
    logic               de_in, hsync_in, vsync_in;
    logic [COLOR_W-1:0] rgb_in;
    logic [3:0]         rom_x, rom_y;
    logic [1:0]         rom_data = 2'b00;
    logic               de_out, hsync_out, vsync_out;
    logic [COLOR_W-1:0] rgb_out;

    cursor_overlay #(
        .H_BITS(H_BITS), .V_BITS(V_BITS), .COLOR_W(COLOR_W),
        .CONTOUR_COLOR(12'h000), .FILL_COLOR(12'hFFF), .SYNC_IDLE(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cursor_en(cursor_en), .fill_solid(fill_solid),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_vld(mouse_vld),
        .frame_start(frame_start), .hcnt(hcnt), .vcnt(vcnt),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .rom_x(rom_x), .rom_y(rom_y), .rom_data(rom_data),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    // Cursor bitmap: top row / left column contour, (15,15) code 11,
    // column 9 transparent, everything else fill.
    function automatic logic [1:0] bmp(input logic [3:0] x, input logic [3:0] y);
        if (x == 4'd0 || y == 4'd0)         return 2'b01;
        else if (x == 4'd15 && y == 4'd15)  return 2'b11;
        else if (x == 4'd9)                 return 2'b00;
        else                                return 2'b10;
    endfunction

    // Registered ROM read, one cycle after the address.
    always @(posedge clk) rom_data <= bmp(rom_x, rom_y);

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_id  = 0;
    logic g_en = 1'b1, g_fill = 1'b1, g_vs = 1'b0;
    logic nxt_mv = 1'b0, nxt_fs = 1'b0;
    int   nxt_mx = 0, nxt_my = 0;

    localparam logic [11:0] BG  = 12'h0F0;
    localparam logic [11:0] CON = 12'h000;
    localparam logic [11:0] FIL = 12'hFFF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_mouse(input int x, input int y);
        nxt_mv = 1'b1;
        nxt_mx = x;
        nxt_my = y;
    endtask

    // Called at a negedge: check the output due now, drive one pixel, queue
    // its expectation, and return at the next negedge.
    task automatic px(input int h, input int v, input logic [11:0] rgb,
                      input logic de, input logic hs, input logic [11:0] exp_rgb);
        exp_t e;
        if (q.size() >= 3) begin
            e = q.pop_front();
            check($sformatf("de#%0d", e.id),  de_out,    e.de);
            check($sformatf("hs#%0d", e.id),  hsync_out, e.hs);
            check($sformatf("vs#%0d", e.id),  vsync_out, e.vs);
            check($sformatf("rgb#%0d", e.id), rgb_out,   e.rgb);
        end
        hcnt        = h[H_BITS-1:0];
        vcnt        = v[V_BITS-1:0];
        rgb_in      = rgb;
        de_in       = de;
        hsync_in    = hs;
        vsync_in    = g_vs;
        cursor_en   = g_en;
        fill_solid  = g_fill;
        mouse_vld   = nxt_mv;
        mouse_x     = nxt_mx[H_BITS-1:0];
        mouse_y     = nxt_my[V_BITS-1:0];
        frame_start = nxt_fs;
        nxt_mv = 1'b0;
        nxt_fs = 1'b0;
        e.de = de; e.hs = hs; e.vs = g_vs; e.rgb = exp_rgb; e.id = n_id++;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(0, 0, 12'h000, 1'b0, 1'b1, 12'h000);
    endtask

    // Called at a negedge: reset across one edge, check reset values,
    // release, and expect two further flushed output cycles.
    task automatic do_reset();
        exp_t e;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_rgb", rgb_out, 12'h000);
        check("rst_de", de_out, 1'b0);
        check("rst_hs", hsync_out, 1'b1);
        check("rst_vs", vsync_out, 1'b1);
        check("rst_rom_x", rom_x, 4'd0);
        check("rst_rom_y", rom_y, 4'd0);
        rst_n = 1'b1;
        q.delete();
        for (int i = 0; i < 2; i++) begin
            e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000; e.id = -1 - i;
            q.push_back(e);
        end
    endtask

    initial begin
        cursor_en = 1'b1; fill_solid = 1'b1; mouse_vld = 1'b0; frame_start = 1'b0;
        mouse_x = '0; mouse_y = '0; hcnt = '0; vcnt = '0;
        de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = '0;
        @(negedge clk);
        do_reset();

        // Position latch at (100,50).
        set_mouse(100, 50); idle(1);
        g_vs = 1'b1; nxt_fs = 1'b1; idle(1); g_vs = 1'b0;
        idle(1);
        px(99, 50, BG, 1, 0, BG);
        px(100, 50, BG, 1, 0, CON);
        px(101, 50, BG, 1, 1, CON);
        px(99, 51, BG, 1, 0, BG);
        px(100, 51, BG, 1, 1, CON);
        px(101, 51, BG, 1, 0, FIL);
        px(102, 51, BG, 1, 0, FIL);
        px(109, 51, BG, 1, 1, BG);
        px(115, 51, BG, 1, 0, FIL);
        px(116, 51, BG, 1, 0, BG);
        px(114, 65, BG, 1, 0, FIL);
        px(115, 65, BG, 1, 0, BG);
        px(100, 65, BG, 1, 0, CON);
        px(100, 66, BG, 1, 0, BG);
        px(101, 51, BG, 0, 0, 12'h000);

        // Fill mode off, then back on; cursor disabled pixel by pixel.
        g_fill = 1'b0;
        px(101, 51, 12'h123, 1, 0, 12'h123);
        px(102, 52, 12'h123, 1, 0, 12'h123);
        px(100, 50, 12'h123, 1, 0, CON);
        g_fill = 1'b1;
        px(101, 51, 12'h123, 1, 0, FIL);
        g_en = 1'b0;
        px(100, 50, BG, 1, 0, BG);
        px(101, 51, BG, 1, 0, BG);
        px(115, 65, BG, 1, 0, BG);
        g_en = 1'b1;
        px(101, 52, BG, 1, 0, FIL);

        // Deferred update: new position only after frame_start.
        set_mouse(200, 80); px(100, 50, BG, 1, 0, CON);
        px(200, 80, BG, 1, 0, BG);
        px(100, 50, BG, 1, 0, CON);
        nxt_fs = 1'b1; idle(1);
        px(200, 80, BG, 1, 0, CON);
        px(100, 50, BG, 1, 0, BG);

        // Simultaneous strobes: act takes old pend (200,80).
        set_mouse(300, 10); nxt_fs = 1'b1; idle(1);
        px(200, 80, BG, 1, 0, CON);
        px(300, 10, BG, 1, 0, BG);
        nxt_fs = 1'b1; idle(1);
        px(300, 10, BG, 1, 0, CON);
        px(200, 80, BG, 1, 0, BG);

        // Edge clip at (2040,1020).
        set_mouse(2040, 1020); idle(1);
        nxt_fs = 1'b1; idle(1);
        px(2039, 1021, BG, 1, 0, BG);
        px(2040, 1021, BG, 1, 0, CON);
        px(2041, 1021, BG, 1, 0, FIL);
        px(2047, 1021, BG, 1, 0, FIL);
        px(0, 1021, BG, 1, 0, BG);
        check("rom_x_nowin", rom_x, 4'd8);
        px(7, 1021, BG, 1, 0, BG);
        px(2041, 1020, BG, 1, 0, CON);
        px(2041, 1023, BG, 1, 0, FIL);
        check("rom_x_lat", rom_x, 4'd1);
        check("rom_y_lat", rom_y, 4'd3);
        px(2041, 0, BG, 1, 0, BG);
        px(2041, 2, BG, 1, 0, BG);

        // Reset mid-line with a pending position that must be lost.
        set_mouse(400, 400); px(2041, 1021, BG, 1, 0, FIL);
        px(2042, 1021, BG, 1, 0, FIL);
        px(2043, 1021, BG, 1, 0, FIL);
        do_reset();
        px(0, 0, BG, 1, 0, CON);
        px(2040, 1020, BG, 1, 0, BG);
        px(1, 1, BG, 1, 0, FIL);
        nxt_fs = 1'b1; idle(1);
        px(0, 0, BG, 1, 0, CON);
        px(400, 400, BG, 1, 0, BG);

        // Alignment of de/hsync with a varying pattern outside the cursor.
        px(500, 500, BG, 1, 0, BG);
        px(501, 500, BG, 0, 0, 12'h000);
        px(502, 500, BG, 1, 1, BG);
        px(503, 500, BG, 1, 0, BG);
        px(504, 500, BG, 0, 1, 12'h000);
        px(505, 500, BG, 1, 1, BG);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
